// File: rtl/cla_serial_adder.sv
// Nibble-serial wide adder: one 4-bit carry-lookahead slice processes the
// operands LSB nibble first, with the inter-nibble carry held in a flop.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for an operand pair, In_ready=1
//   ST_RUN  | one nibble per cycle through the slice, NIB cycles
//   ST_DONE | result held on S/Co/Ovf with Out_valid=1 until Out_ready
module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic             cnt_last;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shift;
    logic             carry_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             co_q;
    logic             ovf_q;

    logic [3:0]       slice_g;
    logic [3:0]       slice_p;
    logic [3:0]       slice_c;
    logic             slice_co;
    logic [3:0]       slice_sum;

    assign cnt_last = (cnt_q == CW'(NIB - 1));

    // Carry-lookahead slice over the low nibble of the operand shift registers
    always_comb begin
        slice_g    = a_q[3:0] & b_q[3:0];
        slice_p    = a_q[3:0] ^ b_q[3:0];
        slice_c[0] = carry_q;
        slice_c[1] = slice_g[0] | (slice_p[0] & carry_q);
        slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0])
                   | (slice_p[1] & slice_p[0] & carry_q);
        slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1])
                   | (slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
        slice_co   = slice_g[3] | (slice_p[3] & slice_g[2])
                   | (slice_p[3] & slice_p[2] & slice_g[1])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
                   | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
        slice_sum  = slice_p ^ slice_c;
    end

    // Sum enters from the top so nibble 0 lands at S[3:0] after NIB shifts
    generate
        if (WIDTH == 4) begin : g_single
            assign sum_shift = slice_sum;
        end else begin : g_multi
            assign sum_shift = {slice_sum, sum_q[WIDTH-1:4]};
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (In_valid)  state_d = ST_RUN;
            ST_RUN:  if (cnt_last)  state_d = ST_DONE;
            ST_DONE: if (Out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        In_ready  = Rst_n && (state_q == ST_IDLE);
        Out_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (In_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Ci;
                        a_msb_q <= A[WIDTH-1];
                        b_msb_q <= B[WIDTH-1];
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_shift;
                    carry_q <= slice_co;
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_last) begin
                        co_q  <= slice_co;
                        ovf_q <= (a_msb_q == b_msb_q) && (slice_sum[3] != a_msb_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign S   = sum_q;
    assign Co  = co_q;
    assign Ovf = ovf_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for cla_serial_adder at WIDTH=16 and WIDTH=4 with
// hand-computed sums, latency, backpressure and mid-operation reset.
module tb_cla_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        co;
    logic        ovf;

    logic        w4_in_valid;
    logic        w4_in_ready;
    logic [3:0]  w4_a;
    logic [3:0]  w4_b;
    logic        w4_ci;
    logic        w4_out_valid;
    logic        w4_out_ready;
    logic [3:0]  w4_s;
    logic        w4_co;
    logic        w4_ovf;

    int checks = 0;
    int errors = 0;

    cla_serial_adder #(.WIDTH(16)) dut16 (
        .Clk(clk), .Rst_n(rst_n),
        .In_valid(in_valid), .In_ready(in_ready),
        .A(a), .B(b), .Ci(ci),
        .Out_valid(out_valid), .Out_ready(out_ready),
        .S(s), .Co(co), .Ovf(ovf)
    );

    cla_serial_adder #(.WIDTH(4)) dut4 (
        .Clk(clk), .Rst_n(rst_n),
        .In_valid(w4_in_valid), .In_ready(w4_in_ready),
        .A(w4_a), .B(w4_b), .Ci(w4_ci),
        .Out_valid(w4_out_valid), .Out_ready(w4_out_ready),
        .S(w4_s), .Co(w4_co), .Ovf(w4_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                        input logic [15:0] es, input logic eco, input logic eovf,
                        input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        ci        = civ;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        ci       = ~civ;
        chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_co"}, 32'(co), 32'(eco));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic civ,
                       input logic [3:0] es, input logic eco, input logic eovf,
                       input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(w4_in_ready), 32'd1);
        w4_in_valid  = 1'b1;
        w4_a         = av;
        w4_b         = bv;
        w4_ci        = civ;
        w4_out_ready = 1'b1;
        @(negedge clk);
        w4_in_valid = 1'b0;
        w4_a        = ~av;
        w4_b        = ~bv;
        n = 0;
        while (!w4_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd1);
        chk({tag, "_s"}, 32'(w4_s), 32'(es));
        chk({tag, "_co"}, 32'(w4_co), 32'(eco));
        chk({tag, "_ovf"}, 32'(w4_ovf), 32'(eovf));
        @(negedge clk);
        chk({tag, "_out_valid_after"}, 32'(w4_out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] held_s;
        int seen_valid;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        ci           = 1'b0;
        out_ready    = 1'b0;
        w4_in_valid  = 1'b0;
        w4_a         = '0;
        w4_b         = '0;
        w4_ci        = 1'b0;
        w4_out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Unknown operands while In_valid=0 must not reach any state
        a  = 'x;
        b  = 'x;
        ci = 1'bx;
        repeat (3) @(negedge clk);
        chk("x_idle_s", 32'(s), 32'd0);
        chk("x_idle_out_valid", 32'(out_valid), 32'd0);

        op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
        op16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");
        op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, "mixed_ci");

        // Backpressure: 0x00FF + 0x0F01 + 1 = 0x1001
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 16'h00FF;
        b         = 16'h0F01;
        ci        = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            a        = 16'hDEAD;
            b        = 16'hBEEF;
            @(negedge clk);
            chk("bp_hold_s", 32'(s), 32'h1001);
            chk("bp_hold_co", 32'(co), 32'd0);
            chk("bp_hold_ovf", 32'(ovf), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_keep_s", 32'(s), 32'h1001);

        op16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "after_bp");

        // Reset during the second RUN cycle aborts the operation
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        ci       = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_co", 32'(co), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("abort_no_result", 32'(seen_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);

        op16(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, "post_abort");

        op4(4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1, "w4_wrap_ovf");
        op4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, "w4_pos_ovf");
        op4(4'h2, 4'h3, 1'b1, 4'h6, 1'b0, 1'b0, "w4_plain");
        op4(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, "w4_full");

        held_s = s;
        chk("w16_untouched", 32'(held_s), 32'h1010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
